// File: rtl/fx_sched_pkg.sv
// fx_sched_pkg: FSM state enum, accumulator width helper and saturate-to-width function for fx_scheduler
package fx_sched_pkg;
  typedef enum logic [2:0] {S_IDLE, S_SELECT, S_ISSUE, S_WAIT, S_ACCUM, S_FINISH} state_t;
  function automatic int acc_width(input int width, input int num_ch);
    return width + $clog2(num_ch);
  endfunction
  function automatic logic signed [31:0] sat(input logic signed [31:0] v, input int width);
    logic signed [31:0] hi;
    hi = (32'sd1 <<< (width - 1)) - 32'sd1;
    return v > hi ? hi : v < -hi - 32'sd1 ? -hi - 32'sd1 : v;
  endfunction
endpackage

// File: rtl/fx_sat_accum.sv
// fx_sat_accum: clearable signed accumulator (ports: clock, reset, clear, add, value in; sat_out = accumulator clamped to WIDTH bits)
module fx_sat_accum import fx_sched_pkg::*; #(
  parameter int WIDTH = 12,
  parameter int AW = 14
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             add,
  input  logic [WIDTH-1:0] value,
  output logic [WIDTH-1:0] sat_out
);
  logic signed [AW-1:0] acc;
  always_ff @(posedge clock or posedge reset)
    if (reset) acc <= '0;
    else if (clear) acc <= '0;
    else if (add) acc <= acc + {{(AW-WIDTH){value[WIDTH-1]}}, value};
  assign sat_out = WIDTH'(sat({{(32-AW){acc[AW-1]}}, acc}, WIDTH));
endmodule

// File: rtl/fx_scheduler.sv
// fx_scheduler: shares one start/done effect unit across NUM_CH channels per sample_tick and emits a saturated mix (ports: clock, reset, sample_tick, ch_sample, ch_enable, fx_result, fx_done in; fx_start, fx_sample, mix_out, mix_valid, busy, overrun, fx_timeout out; FX_SCHED_TIMEOUT_EN adds a WAIT timeout with dry-sample fallback)
module fx_scheduler import fx_sched_pkg::*; #(
  parameter int NUM_CH = 4,
  parameter int WIDTH = 12,
  parameter int TIMEOUT = 15
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    sample_tick,
  input  logic [NUM_CH*WIDTH-1:0] ch_sample,
  input  logic [NUM_CH-1:0]       ch_enable,
  output logic                    fx_start,
  output logic [WIDTH-1:0]        fx_sample,
  input  logic [WIDTH-1:0]        fx_result,
  input  logic                    fx_done,
  output logic [WIDTH-1:0]        mix_out,
  output logic                    mix_valid,
  output logic                    busy,
  output logic                    overrun,
  output logic                    fx_timeout
);
  localparam int AW = acc_width(WIDTH, NUM_CH);
  localparam int IW = $clog2(NUM_CH + 1);
  localparam logic [IW-1:0] LAST = IW'(NUM_CH);
  state_t state, nxt;
  logic [NUM_CH*WIDTH-1:0] lat_sample;
  logic [NUM_CH-1:0] lat_en;
  logic [IW-1:0] idx;
  logic [WIDTH-1:0] cur_sample, cap, acc_sat;
  logic cur_en, tmo;
`ifdef FX_SCHED_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] wait_cnt;
  always_ff @(posedge clock or posedge reset)
    if (reset) wait_cnt <= '0;
    else wait_cnt <= state == S_ISSUE ? '0 : state == S_WAIT ? wait_cnt + TW'(1) : wait_cnt;
  assign tmo = state == S_WAIT && !fx_done && wait_cnt == TW'(TIMEOUT - 1);
`else
  logic unused_timeout;
  assign unused_timeout = |TIMEOUT;
  assign tmo = 1'b0;
`endif
  always_comb begin
    cur_sample = '0;
    cur_en = 1'b0;
    for (int i = 0; i < NUM_CH; i++)
      if (idx == IW'(i)) begin
        cur_sample = lat_sample[i*WIDTH +: WIDTH];
        cur_en = lat_en[i];
      end
  end
  always_ff @(posedge clock or posedge reset)
    if (reset) state <= S_IDLE;
    else state <= nxt;
  always_comb
    nxt = state == S_IDLE   ? (sample_tick ? S_SELECT : S_IDLE)
        : state == S_SELECT ? (idx == LAST ? S_FINISH : cur_en ? S_ISSUE : S_SELECT)
        : state == S_ISSUE  ? S_WAIT
        : state == S_WAIT   ? (fx_done || tmo ? S_ACCUM : S_WAIT)
        : state == S_ACCUM  ? S_SELECT
        : S_IDLE;
  assign fx_start = state == S_ISSUE || state == S_WAIT;
  assign busy = state != S_IDLE;
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      lat_sample <= '0;
      lat_en <= '0;
      idx <= '0;
      fx_sample <= '0;
      cap <= '0;
      mix_out <= '0;
      mix_valid <= 1'b0;
      overrun <= 1'b0;
      fx_timeout <= 1'b0;
    end else begin
      mix_valid <= state == S_FINISH;
      overrun <= sample_tick && state != S_IDLE;
      fx_timeout <= tmo;
      if (state == S_IDLE && sample_tick) begin
        lat_sample <= ch_sample;
        lat_en <= ch_enable;
        idx <= '0;
      end
      if (state == S_SELECT && idx != LAST) begin
        if (cur_en) fx_sample <= cur_sample;
        else idx <= idx + IW'(1);
      end
      if (state == S_WAIT) cap <= fx_done ? fx_result : cur_sample;
      if (state == S_ACCUM) idx <= idx + IW'(1);
      if (state == S_FINISH) mix_out <= acc_sat;
    end
  fx_sat_accum #(.WIDTH(WIDTH), .AW(AW)) u_accum (
    .clock(clock),
    .reset(reset),
    .clear(state == S_IDLE && sample_tick),
    .add(state == S_ACCUM),
    .value(cap),
    .sat_out(acc_sat)
  );
endmodule

// File: tb/tb_fx_scheduler.sv
// tb_fx_scheduler: randomized self-checking bench for fx_scheduler with a behavioural effect-unit responder and frame model
module tb_fx_scheduler;
  localparam int N = 4, W = 12, TO = 15;
  logic clock = 0, reset = 1, sample_tick = 0;
  logic [N*W-1:0] ch_sample = '0;
  logic [N-1:0] ch_enable = '0;
  logic fx_start, fx_done = 0, mix_valid, busy, overrun, fx_timeout;
  logic [W-1:0] fx_sample, fx_result = '0, mix_out;
  int errors = 0, checks = 0;
  int lat_fixed = 1, fn_sel = 0, cnt = 0, cur_lat = 1, hang_val = 0, n_tmo = 0;
  bit stale = 0, hang_en = 0, hang = 0;
  int k_q[$];
  always #5 clock = ~clock;
  fx_scheduler #(.NUM_CH(N), .WIDTH(W), .TIMEOUT(TO)) dut (
    .clock(clock), .reset(reset), .sample_tick(sample_tick), .ch_sample(ch_sample),
    .ch_enable(ch_enable), .fx_start(fx_start), .fx_sample(fx_sample), .fx_result(fx_result),
    .fx_done(fx_done), .mix_out(mix_out), .mix_valid(mix_valid), .busy(busy),
    .overrun(overrun), .fx_timeout(fx_timeout)
  );
  function automatic int fx_fn(input int s, input int f);
    return f != 0 ? s >>> 1 : s;
  endfunction
  always @(negedge clock) begin
    if (fx_timeout) n_tmo++;
    if (fx_start) begin
      cnt++;
      if (cnt == 1) begin
        cur_lat = lat_fixed > 0 ? lat_fixed : int'($urandom_range(1, 4));
        hang = hang_en && $signed(fx_sample) == hang_val;
        k_q.push_back(hang ? TO : cur_lat);
      end
      fx_done = (!hang && cnt >= cur_lat + 1) || (stale && cnt == 1);
      fx_result = (fx_done && cnt > 1) ? W'(fx_fn($signed(fx_sample), fn_sel)) : 12'h5A5;
    end else begin
      cnt = 0;
      fx_done = stale && fx_done;
    end
  end
  task automatic run_frame(input int s0, input int s1, input int s2, input int s3,
                           input logic [3:0] en, input int fsel, input int ovr_at, input string name);
    int s[4];
    int sum, nen, edges, exp_lat;
    logic [N*W-1:0] pk;
    logic [W-1:0] exp_mix;
    s = '{s0, s1, s2, s3};
    sum = 0; nen = 0; edges = 0;
    for (int i = 0; i < N; i++) begin
      pk[i*W +: W] = W'(s[i]);
      if (en[i]) begin
        nen++;
        sum += (hang_en && s[i] == hang_val) ? s[i] : fx_fn(s[i], fsel);
      end
    end
    exp_mix = W'(sum > 2047 ? 2047 : sum < -2048 ? -2048 : sum);
    fn_sel = fsel;
    k_q.delete();
    @(negedge clock);
    ch_sample = pk; ch_enable = en; sample_tick = 1;
    @(negedge clock);
    sample_tick = 0; ch_sample = ~pk; ch_enable = ~en;
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL %s busy_rise: got %b expected 1", name, busy); end
    while (!mix_valid && edges < 1000) begin
      @(negedge clock);
      edges++;
      if (sample_tick) sample_tick = 0;
      if (ovr_at > 0 && edges == ovr_at) begin
        checks++;
        if (overrun !== 1'b1) begin errors++; $display("FAIL %s overrun: got %b expected 1", name, overrun); end
      end
      if (ovr_at > 0 && edges == ovr_at - 1) sample_tick = 1;
    end
    checks++;
    if (mix_valid !== 1'b1) begin errors++; $display("FAIL %s mix_valid_seen: got %b expected 1 within 1000 cycles", name, mix_valid); end
    exp_lat = N - nen + 2;
    foreach (k_q[i]) exp_lat += 3 + k_q[i];
    checks++;
    if (k_q.size() != nen) begin errors++; $display("FAIL %s transactions: got %0d expected %0d", name, k_q.size(), nen); end
    checks++;
    if (edges != exp_lat) begin errors++; $display("FAIL %s latency: got edge %0d expected edge %0d", name, edges, exp_lat); end
    checks++;
    if (mix_out !== exp_mix) begin errors++; $display("FAIL %s mix_out: got %0d expected %0d", name, $signed(mix_out), $signed(exp_mix)); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL %s busy_fall: got %b expected 0", name, busy); end
    @(negedge clock);
    checks++;
    if ({mix_valid, busy} !== 2'b00) begin errors++; $display("FAIL %s pulse_end: got valid/busy %b expected 00", name, {mix_valid, busy}); end
    checks++;
    if (mix_out !== exp_mix) begin errors++; $display("FAIL %s mix_hold: got %0d expected %0d", name, $signed(mix_out), $signed(exp_mix)); end
  endtask
  task automatic test_reset();
    repeat (2) @(negedge clock);
    checks++;
    if ({fx_start, fx_sample, mix_out, mix_valid, busy, overrun, fx_timeout} !== '0)
      begin errors++; $display("FAIL reset_state: got start=%b sample=%h mix=%h valid=%b busy=%b ovr=%b tmo=%b expected all 0",
        fx_start, fx_sample, mix_out, mix_valid, busy, overrun, fx_timeout); end
    reset = 0;
  endtask
  task automatic test_basic();
    lat_fixed = 1;
    run_frame(100, 200, -50, 10, 4'hF, 0, 0, "basic");
  endtask
  task automatic test_saturation();
    lat_fixed = 1;
    run_frame(2047, 2047, 2047, 2047, 4'hF, 0, 0, "sat_pos");
    run_frame(-2048, -2048, -2048, -2048, 4'hF, 0, 0, "sat_neg");
  endtask
  task automatic test_enable();
    lat_fixed = 1;
    run_frame(5, 7, 9, 11, 4'b0101, 0, 0, "partial_enable");
    run_frame(123, -45, 67, 8, 4'b0000, 0, 0, "no_enable");
  endtask
  task automatic test_stale_done();
    stale = 1; lat_fixed = 3;
    run_frame(111, -222, 333, -444, 4'hF, 0, 0, "stale_done");
    stale = 0;
  endtask
  task automatic test_overrun();
    lat_fixed = 2;
    run_frame(40, -30, 20, -10, 4'hF, 1, 7, "overrun_mid");
    lat_fixed = 1;
    run_frame(1, 2, 3, 4, 4'hF, 0, 18, "overrun_finish");
  endtask
  task automatic test_random();
    lat_fixed = 0;
    for (int f = 0; f < 8; f++)
      run_frame(int'($urandom_range(0, 4095)) - 2048, int'($urandom_range(0, 4095)) - 2048,
                int'($urandom_range(0, 4095)) - 2048, int'($urandom_range(0, 4095)) - 2048,
                4'($urandom_range(0, 15)), int'($urandom_range(0, 1)), 0, "random");
    lat_fixed = 1;
  endtask
`ifdef FX_SCHED_TIMEOUT_EN
  task automatic test_timeout();
    int t0;
    t0 = n_tmo;
    hang_en = 1; hang_val = 300; lat_fixed = 1;
    run_frame(50, 300, -20, 7, 4'hF, 0, 0, "timeout");
    checks++;
    if (n_tmo - t0 != 1) begin errors++; $display("FAIL timeout_pulses: got %0d expected 1", n_tmo - t0); end
    hang_en = 0;
  endtask
`endif
  task automatic test_reset_mid();
    int waited, seen;
    waited = 0; seen = 0;
    lat_fixed = 10;
    @(negedge clock);
    ch_sample = {12'd4, 12'd3, 12'd2, 12'd1}; ch_enable = 4'hF; sample_tick = 1;
    @(negedge clock);
    sample_tick = 0;
    while (!fx_start && waited < 20) begin @(negedge clock); waited++; end
    repeat (3) @(negedge clock);
    checks++;
    if (fx_start !== 1'b1) begin errors++; $display("FAIL reset_mid_pre: got fx_start %b expected 1", fx_start); end
    reset = 1;
    #1;
    checks++;
    if ({fx_start, busy} !== 2'b00) begin errors++; $display("FAIL reset_mid_async: got start/busy %b expected 00", {fx_start, busy}); end
    repeat (2) @(negedge clock);
    reset = 0;
    repeat (40) begin @(negedge clock); if (mix_valid) seen++; end
    checks++;
    if (seen != 0 || busy !== 1'b0) begin errors++; $display("FAIL reset_mid_after: got %0d mix_valid, busy %b expected 0 and 0", seen, busy); end
    lat_fixed = 1;
  endtask
  initial begin
    test_reset();
    test_basic();
    test_saturation();
    test_enable();
    test_stale_done();
    test_overrun();
    test_random();
`ifdef FX_SCHED_TIMEOUT_EN
    test_timeout();
`else
    checks++;
    if (n_tmo != 0) begin errors++; $display("FAIL timeout_tied: got %0d pulses expected 0", n_tmo); end
`endif
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/fx_scheduler.md
# fx_scheduler

Time-multiplexes one shared start/done audio effect unit (bitcrusher-class, 12-bit signed) across `NUM_CH` drum voice channels. The block is tick-driven: on each audio sample tick it latches every channel's sample and runs each enabled channel through the effect unit in turn. It then sums the processed samples with saturation and presents one mixed sample to the output stage. It sits between the per-voice sample generators and the audio output path.

## Interface
- `NUM_CH`, 4: number of voice channels (2..8).
- `WIDTH`, 12: signed sample width.
- `TIMEOUT`, 15: maximum WAIT cycles per channel before fallback (used only when `FX_SCHED_TIMEOUT_EN` is defined).

Ports:
- `clock`  in  1  system clock.
- `reset`  in  1  asynchronous, active-high reset.
- `sample_tick`  in  1  one-cycle pulse per audio sample period.
- `ch_sample`  in  NUM_CH*WIDTH  packed signed channel samples; channel i occupies bits [i*WIDTH +: WIDTH].
- `ch_enable`  in  NUM_CH  per-channel enable; a disabled channel contributes 0.
- `fx_start`  out  1  request to the effect unit; held high for the whole transaction.
- `fx_sample`  out  WIDTH  sample sent to the effect unit; stable while `fx_start` is high.
- `fx_result`  in  WIDTH  processed sample returned by the effect unit.
- `fx_done`  in  1  effect-unit completion (level).
- `mix_out`  out  WIDTH  saturated sum of the processed samples.
- `mix_valid`  out  1  one-cycle strobe marking a new `mix_out`.
- `busy`  out  1  high whenever the FSM is not in IDLE.
- `overrun`  out  1  one-cycle pulse when a `sample_tick` is dropped.
- `fx_timeout`  out  1  one-cycle pulse when a channel falls back to its dry sample.

## Operation
- Reset values: all outputs 0; FSM in IDLE; accumulator 0; channel index 0. Reset is asynchronous, so `fx_start` drops immediately and any in-flight frame is discarded without a `mix_valid`.
- FSM states: IDLE, SELECT, ISSUE, WAIT, ACCUM, FINISH.
- IDLE: on `sample_tick`, latch `ch_sample` and `ch_enable`, clear the accumulator, set idx=0, and go to SELECT.
- SELECT:
  - If idx==NUM_CH, go to FINISH.
  - Else, if the latched enable[idx] is set, drive `fx_sample` with sample[idx] and go to ISSUE.
  - Else, idx++ and stay in SELECT.
- ISSUE: `fx_start`=1; `fx_done` is ignored this cycle, because it can still be high from the previous transaction. Go to WAIT.
- WAIT: `fx_start`=1; `fx_done` is sampled every cycle.
  - If `fx_done`=1, capture `fx_result` and go to ACCUM.
  - On timeout (see Configuration), capture the dry sample[idx], pulse `fx_timeout`, and go to ACCUM.
- ACCUM: `fx_start`=0; add the captured value, sign-extended to WIDTH+clog2(NUM_CH) bits, to the accumulator; idx++; go to SELECT.
- FINISH: clamp the accumulator to [-2^(WIDTH-1), 2^(WIDTH-1)-1], register it to `mix_out`, pulse `mix_valid`, and go to IDLE.
- `mix_out` holds its value until the next FINISH.
- A frame with no enabled channels produces `mix_out`=0 with `mix_valid`.
- `sample_tick` in any state other than IDLE, including the FINISH cycle, is dropped; `overrun` pulses on the following cycle. The frame in progress is not affected.
- Changes to `ch_sample` or `ch_enable` after the latch have no effect until the next accepted tick.

## Timing
- Channel cost: an enabled channel whose `fx_done` is seen on WAIT cycle k (k≥1) costs 3+k cycles. A disabled channel costs 1 cycle.
- Latency: with the tick sampled at edge 0, `mix_valid` is high for exactly one cycle after edge Σ(3+k_i) + D + 2, where D is the number of disabled channels.
  - Example: NUM_CH=4, all enabled, k=1 gives `mix_valid` after edge 18.
- `fx_start` deasserts for at least one cycle (ACCUM) between consecutive transactions.
- `busy` rises the cycle after the tick and falls on the same edge that asserts `mix_valid`.

## Configuration
- `FX_SCHED_TIMEOUT_EN` defined:
  - A WAIT counter, cleared in ISSUE, increments each WAIT cycle.
  - On the TIMEOUT-th WAIT cycle without `fx_done`, the channel uses its dry sample and `fx_timeout` pulses.
  - If `fx_done` and the timeout occur in the same cycle, `fx_done` wins.
- Undefined: WAIT has no exit other than `fx_done`, and `fx_timeout` is tied to 0.

## Structure
- `fx_sched_pkg`: FSM state enum; accumulator width constant; saturate-to-WIDTH function.
- Sub-module `fx_sat_accum`: clearable signed accumulator with a saturating read port, instantiated once.

## Test plan
- NUM_CH=4, all enabled, samples 100/200/-50/10, effect unit echoing the sample with done at k=1 -> `mix_out`=260, `mix_valid` after edge 18.
- Samples 2047×4, all enabled -> `mix_out`=2047 (saturated); samples -2048×4 -> `mix_out`=-2048.
- `ch_enable`=4'b0101, samples 5/7/9/11 -> exactly two `fx_start` transactions, `mix_out`=14, `mix_valid` after edge 12.
- `fx_done` held high from the previous transaction, real result at k=3 -> the stale done is ignored in ISSUE and the k=3 result is used.
- `FX_SCHED_TIMEOUT_EN` defined, `fx_done` never asserted for ch1 (sample 300) -> `fx_timeout` pulse, 300 used dry, frame completes.
- `sample_tick` mid-frame -> `overrun` pulse, frame result unchanged; `reset` mid-WAIT -> `fx_start`=0 immediately, no `mix_valid`, IDLE.
